// File: rtl/biriscv_fetch_queue_pkg.sv
// biriscv_fetch_queue_pkg: shared types and constants for the fetch queue.
// Holds the info-flag bit positions and the packed queue entry layout
// {instr, pc, info} used by the queue top level and its entry RAM.
package biriscv_fetch_queue_pkg;

  localparam int FQ_INFO_W = 11;

  // Bit positions inside the 11-bit decode info field.
  localparam int FQ_INFO_FAULT_FETCH = 0;
  localparam int FQ_INFO_FAULT_PAGE  = 1;
  localparam int FQ_INFO_EXEC        = 2;
  localparam int FQ_INFO_LSU         = 3;
  localparam int FQ_INFO_BRANCH      = 4;
  localparam int FQ_INFO_MUL         = 5;
  localparam int FQ_INFO_DIV         = 6;
  localparam int FQ_INFO_CSR         = 7;
  localparam int FQ_INFO_RD_VALID    = 8;
  localparam int FQ_INFO_INVALID     = 9;
  localparam int FQ_INFO_MULF        = 10;

  typedef struct packed {
    logic [31:0]          instr;
    logic [31:0]          pc;
    logic [FQ_INFO_W-1:0] info;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/biriscv_fetch_queue_ram.sv
// biriscv_fetch_queue_ram: DEPTH x fq_entry_t storage, 2 write / 2 async read.
// Ports: clk_i, rst_ni (async clear of all entries), wr0/wr1 enable+addr+data,
// rd0/rd1 addr in, data out combinationally. Writes land on the clock edge.
module biriscv_fetch_queue_ram
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr0_en_i,
  input  logic [DEPTH_W-1:0] wr0_addr_i,
  input  fq_entry_t          wr0_data_i,
  input  logic               wr1_en_i,
  input  logic [DEPTH_W-1:0] wr1_addr_i,
  input  fq_entry_t          wr1_data_i,
  input  logic [DEPTH_W-1:0] rd0_addr_i,
  output fq_entry_t          rd0_data_o,
  input  logic [DEPTH_W-1:0] rd1_addr_i,
  output fq_entry_t          rd1_data_o
);

  fq_entry_t mem_q [DEPTH];

  // The two write addresses are always consecutive entries, so they never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en_i) mem_q[wr0_addr_i] <= wr0_data_i;
      if (wr1_en_i) mem_q[wr1_addr_i] <= wr1_data_i;
    end
  end

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/biriscv_fetch_queue.sv
// biriscv_fetch_queue: in-order dual-write/dual-read instruction queue between
// frontend fetch0/fetch1 and issue. Ports: flush_i, in0/in1 (valid, instr, pc,
// info, accept), out0/out1 (valid, instr, pc, info, accept); entries visible 1 cycle
// after write. Optional BIRISCV_FETCH_QUEUE_PERF_EN adds perf_full_stall_o and
// perf_occupancy_max_o.
module biriscv_fetch_queue
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in0_valid_i,
  input  logic [31:0]          in0_instr_i,
  input  logic [31:0]          in0_pc_i,
  input  logic [FQ_INFO_W-1:0] in0_info_i,
  output logic                 in0_accept_o,
  input  logic                 in1_valid_i,
  input  logic [31:0]          in1_instr_i,
  input  logic [31:0]          in1_pc_i,
  input  logic [FQ_INFO_W-1:0] in1_info_i,
  output logic                 in1_accept_o,
  output logic                 out0_valid_o,
  output logic [31:0]          out0_instr_o,
  output logic [31:0]          out0_pc_o,
  output logic [FQ_INFO_W-1:0] out0_info_o,
  input  logic                 out0_accept_i,
  output logic                 out1_valid_o,
  output logic [31:0]          out1_instr_o,
  output logic [31:0]          out1_pc_o,
  output logic [FQ_INFO_W-1:0] out1_info_o,
  input  logic                 out1_accept_i
`ifdef BIRISCV_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]          perf_full_stall_o,
  output logic [DEPTH_W:0]     perf_occupancy_max_o
`endif
);

  localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0]   CNT_TWO  = (DEPTH_W+1)'(2);
  localparam logic [DEPTH_W:0]   CNT_LIM0 = (DEPTH_W+1)'(DEPTH-1);
  localparam logic [DEPTH_W:0]   CNT_LIM1 = (DEPTH_W+1)'(DEPTH-2);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic [1:0]         push_n, pop_n;
  logic               pop1, pop2;
  fq_entry_t          wr0_data, wr1_data, rd0_data, rd1_data;

  // Write-side handshake looks only at the registered count, never at the read side.
  assign in0_accept_o = !flush_i && in0_valid_i && (count_q <= CNT_LIM0);
  assign in1_accept_o = in0_accept_o && in1_valid_i && (count_q <= CNT_LIM1);

  assign out0_valid_o = !flush_i && (count_q >= CNT_ONE);
  assign out1_valid_o = !flush_i && (count_q >= CNT_TWO);

  // out1_accept_i alone does nothing: head must leave first to keep order.
  assign pop2 = out0_valid_o && out0_accept_i && out1_valid_o && out1_accept_i;
  assign pop1 = out0_valid_o && out0_accept_i && !pop2;

  assign push_n = in1_accept_o ? 2'd2 : (in0_accept_o ? 2'd1 : 2'd0);
  assign pop_n  = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_W'(push_n);
    rd_ptr_d = rd_ptr_q + DEPTH_W'(pop_n);
    count_d  = count_q + (DEPTH_W+1)'(push_n) - (DEPTH_W+1)'(pop_n);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr0_data = '{instr: in0_instr_i, pc: in0_pc_i, info: in0_info_i};
  assign wr1_data = '{instr: in1_instr_i, pc: in1_pc_i, info: in1_info_i};

  biriscv_fetch_queue_ram #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr0_en_i   (in0_accept_o),
    .wr0_addr_i (wr_ptr_q),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (in1_accept_o),
    .wr1_addr_i (wr_ptr_q + PTR_ONE),
    .wr1_data_i (wr1_data),
    .rd0_addr_i (rd_ptr_q),
    .rd0_data_o (rd0_data),
    .rd1_addr_i (rd_ptr_q + PTR_ONE),
    .rd1_data_o (rd1_data)
  );

  assign out0_instr_o = rd0_data.instr;
  assign out0_pc_o    = rd0_data.pc;
  assign out0_info_o  = rd0_data.info;
  assign out1_instr_o = rd1_data.instr;
  assign out1_pc_o    = rd1_data.pc;
  assign out1_info_o  = rd1_data.info;

`ifdef BIRISCV_FETCH_QUEUE_PERF_EN
  logic [31:0]      stall_q;
  logic [DEPTH_W:0] occ_max_q;

  // Tracking count_d keeps the high-water mark in step with the count itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q   <= '0;
      occ_max_q <= '0;
    end else begin
      if (in0_valid_i && !in0_accept_o && !flush_i && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (count_d > occ_max_q) begin
        occ_max_q <= count_d;
      end
    end
  end

  assign perf_full_stall_o    = stall_q;
  assign perf_occupancy_max_o = occ_max_q;
`endif

  // Slot 1 without slot 0 breaks program order from the frontend.
  a_in1_needs_in0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in1_valid_i && !in0_valid_i));

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
module tb_biriscv_fetch_queue;
  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [10:0] info;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in0_valid, in1_valid, in0_accept, in1_accept;
  logic [31:0] in0_instr, in0_pc, in1_instr, in1_pc;
  logic [10:0] in0_info, in1_info;
  logic        out0_valid, out1_valid, out0_accept, out1_accept;
  logic [31:0] out0_instr, out0_pc, out1_instr, out1_pc;
  logic [10:0] out0_info, out1_info;
`ifdef BIRISCV_FETCH_QUEUE_PERF_EN
  logic [31:0]      perf_stall;
  logic [DEPTH_W:0] perf_occ;
`endif

  int checks = 0;
  int errors = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  biriscv_fetch_queue #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in0_valid_i(in0_valid), .in0_instr_i(in0_instr), .in0_pc_i(in0_pc),
    .in0_info_i(in0_info), .in0_accept_o(in0_accept),
    .in1_valid_i(in1_valid), .in1_instr_i(in1_instr), .in1_pc_i(in1_pc),
    .in1_info_i(in1_info), .in1_accept_o(in1_accept),
    .out0_valid_o(out0_valid), .out0_instr_o(out0_instr), .out0_pc_o(out0_pc),
    .out0_info_o(out0_info), .out0_accept_i(out0_accept),
    .out1_valid_o(out1_valid), .out1_instr_o(out1_instr), .out1_pc_o(out1_pc),
    .out1_info_o(out1_info), .out1_accept_i(out1_accept)
`ifdef BIRISCV_FETCH_QUEUE_PERF_EN
    , .perf_full_stall_o(perf_stall), .perf_occupancy_max_o(perf_occ)
`endif
  );

  task automatic set_in(input bit v0, input bit v1, input logic [31:0] p0, input logic [31:0] p1,
                        input bit a0, input bit a1, input bit fl);
    in0_valid = v0; in1_valid = v1 & v0; in0_pc = p0; in1_pc = p1;
    in0_instr = $urandom(); in1_instr = $urandom();
    in0_info = 11'($urandom()); in1_info = 11'($urandom());
    out0_accept = a0; out1_accept = a1; flush = fl;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; the reference queue applies flush, else pops then pushes.
  task automatic tick();
    int sz = mq.size();
    bit a0 = !flush && in0_valid && (sz < DEPTH);
    bit a1 = a0 && in1_valid && (sz <= DEPTH - 2);
    int np = 0;
    ent_t e0 = '{instr: in0_instr, pc: in0_pc, info: in0_info};
    ent_t e1 = '{instr: in1_instr, pc: in1_pc, info: in1_info};
    if (!flush && out0_accept && sz >= 1) np = (out1_accept && sz >= 2) ? 2 : 1;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      repeat (np) void'(mq.pop_front());
      if (a0) mq.push_back(e0);
      if (a1) mq.push_back(e1);
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (DEPTH) tick();
    set_idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL rst_out0_valid got %b exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_out1_valid got %b exp 0", out1_valid); end
    checks++; if (in0_accept !== 1'b0) begin errors++; $display("FAIL rst_in0_accept got %b exp 0", in0_accept); end
    rst_n = 1'b1;
    #1;
    set_in(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL idle_out0_valid got %b exp 0", out0_valid); end
    checks++; if (in0_accept !== 1'b1) begin errors++; $display("FAIL first_accept got %b exp 1", in0_accept); end
    tick();
    set_idle();
    #1;
    checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL first_visible got %b exp 1", out0_valid); end
    checks++; if (out0_pc !== 32'h8000_0000) begin errors++; $display("FAIL first_pc got %h exp 80000000", out0_pc); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL first_out1_valid got %b exp 0", out1_valid); end
    drain();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 32'h8000_0000 + 32'(8*k), 32'h8000_0004 + 32'(8*k), 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if ({in0_accept, in1_accept} !== 2'b11) begin errors++; $display("FAIL fill_accept[%0d] got %b exp 11", k, {in0_accept, in1_accept}); end
      tick();
    end
    set_in(1'b1, 1'b1, 32'h9000_0000, 32'h9000_0004, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({in0_accept, in1_accept} !== 2'b00) begin errors++; $display("FAIL full_accept got %b exp 00", {in0_accept, in1_accept}); end
    checks++; if ({out0_valid, out1_valid} !== 2'b11) begin errors++; $display("FAIL full_valid got %b exp 11", {out0_valid, out1_valid}); end
    checks++; if (out0_pc !== 32'h8000_0000) begin errors++; $display("FAIL full_out0_pc got %h exp 80000000", out0_pc); end
    checks++; if (out1_pc !== 32'h8000_0004) begin errors++; $display("FAIL full_out1_pc got %h exp 80000004", out1_pc); end
    checks++; if (out0_instr !== mq[0].instr) begin errors++; $display("FAIL full_out0_instr got %h exp %h", out0_instr, mq[0].instr); end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (out0_pc !== 32'h8000_0000 + 32'(8*k) || out1_pc !== 32'h8000_0004 + 32'(8*k)) begin
        errors++; $display("FAIL fill_drain[%0d] got %h/%h exp %h/%h", k, out0_pc, out1_pc, 32'h8000_0000 + 32'(8*k), 32'h8000_0004 + 32'(8*k)); end
      tick();
    end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", out0_valid); end
    set_idle();
  endtask

  task automatic test_count7();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 32'h1018, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({in0_accept, in1_accept} !== 2'b10) begin errors++; $display("FAIL cnt7_accept got %b exp 10", {in0_accept, in1_accept}); end
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i < 7) ? 32'h1000 + 32'(4*i) : 32'h2000;
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (out0_pc !== exp_pc) begin errors++; $display("FAIL cnt7_order[%0d] got %h exp %h", i, out0_pc, exp_pc); end
      tick();
    end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL cnt7_empty got %b exp 0", out0_valid); end
    set_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    rst_n = 1'b1;
    #1;
    // Seven single pushes with trailing single pops leave wr_ptr = rd_ptr = 7.
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 1'b0, 32'h40 + 32'(4*i), 32'h0, i > 0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({out0_valid, in0_accept, in1_accept} !== 3'b011) begin errors++; $display("FAIL wrap_pre got %b exp 011", {out0_valid, in0_accept, in1_accept}); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if ({out0_valid, out1_valid} !== 2'b11) begin errors++; $display("FAIL wrap_valid got %b exp 11", {out0_valid, out1_valid}); end
    checks++; if (out0_pc !== 32'h100) begin errors++; $display("FAIL wrap_out0_pc got %h exp 100", out0_pc); end
    checks++; if (out1_pc !== 32'h104) begin errors++; $display("FAIL wrap_out1_pc got %h exp 104", out1_pc); end
    tick();
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL wrap_empty got %b exp 00", {out0_valid, out1_valid}); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc_wr = 32'h3000;
    logic [31:0] pc_rd = 32'h3000;
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 1'b1, pc_wr, pc_wr + 32'd4, 1'b0, 1'b0, 1'b0);
      tick();
      pc_wr += 32'd8;
    end
    for (int k = 0; k < 50; k++) begin
      set_in(1'b1, 1'b1, pc_wr, pc_wr + 32'd4, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (out0_pc !== pc_rd || out1_pc !== pc_rd + 32'd4) begin
        errors++; $display("FAIL b2b_order[%0d] got %h/%h exp %h/%h", k, out0_pc, out1_pc, pc_rd, pc_rd + 32'd4); end
      checks++; if ({in1_accept, out1_valid} !== 2'b11) begin errors++; $display("FAIL b2b_rate[%0d] got %b exp 11", k, {in1_accept, out1_valid}); end
      tick();
      pc_wr += 32'd8;
      pc_rd += 32'd8;
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (out0_pc !== pc_rd || out1_pc !== pc_rd + 32'd4) begin
        errors++; $display("FAIL b2b_tail[%0d] got %h/%h exp %h/%h", k, out0_pc, out1_pc, pc_rd, pc_rd + 32'd4); end
      tick();
      pc_rd += 32'd8;
    end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out0_valid); end
    set_idle();
  endtask

  task automatic test_flush();
    set_in(1'b1, 1'b1, 32'h5000, 32'h5004, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b1, 32'h5008, 32'h500c, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h5010, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 1'b1, 32'h7000, 32'h7004, 1'b1, 1'b1, 1'b1);
      #1;
      checks++; if ({out0_valid, out1_valid, in0_accept, in1_accept} !== 4'b0000) begin
        errors++; $display("FAIL flush_force[%0d] got %b exp 0000", c, {out0_valid, out1_valid, in0_accept, in1_accept}); end
      tick();
    end
    set_in(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({out0_valid, in0_accept} !== 2'b01) begin errors++; $display("FAIL flush_after got %b exp 01", {out0_valid, in0_accept}); end
    tick();
    set_idle();
    #1;
    checks++; if ({out0_valid, out1_valid} !== 2'b10 || out0_pc !== 32'h6000) begin
      errors++; $display("FAIL flush_next got %b/%h exp 10/6000", {out0_valid, out1_valid}, out0_pc); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit v0, e_a0, e_a1, e_v0, e_v1;
      int sz;
      v0 = 1'($urandom());
      set_in(v0, 1'($urandom()), $urandom(), $urandom(), 1'($urandom()), 1'($urandom()),
             $urandom_range(0, 19) == 0);
      #1;
      sz   = mq.size();
      e_a0 = !flush && in0_valid && sz < DEPTH;
      e_a1 = e_a0 && in1_valid && sz <= DEPTH - 2;
      e_v0 = !flush && sz >= 1;
      e_v1 = !flush && sz >= 2;
      checks++; if ({in0_accept, in1_accept, out0_valid, out1_valid} !== {e_a0, e_a1, e_v0, e_v1}) begin
        errors++; $display("FAIL rnd_hs[%0d] got %b exp %b", c, {in0_accept, in1_accept, out0_valid, out1_valid}, {e_a0, e_a1, e_v0, e_v1}); end
      if (e_v0) begin
        checks++; if ({out0_instr, out0_pc, out0_info} !== {mq[0].instr, mq[0].pc, mq[0].info}) begin
          errors++; $display("FAIL rnd_out0[%0d] got %h/%h/%h exp %h/%h/%h", c, out0_instr, out0_pc, out0_info, mq[0].instr, mq[0].pc, mq[0].info); end
      end
      if (e_v1) begin
        checks++; if ({out1_instr, out1_pc, out1_info} !== {mq[1].instr, mq[1].pc, mq[1].info}) begin
          errors++; $display("FAIL rnd_out1[%0d] got %h/%h/%h exp %h/%h/%h", c, out1_instr, out1_pc, out1_info, mq[1].instr, mq[1].pc, mq[1].info); end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_fill();
    test_count7();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
